dmem_responder: RTL and testbench

- Slave/responder end of the data-memory interface driven by the CPU pipeline's MEM stage.
- Accepts one load or store request at a time and stores data in a word-organised internal array.
- Builds byte lanes for SB/SH/SW stores; extracts and sign- or zero-extends LB/LH/LW/LBU/LHU loads.
- Configurable access latency, exposed through a busy/done handshake.

---
 rtl/dmem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the MEM-stage data-memory interface.
// Word-organised array with byte-lane stores and sign/zero-extending loads,
// fixed access latency and a busy/done handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (flag misaligned accesses
// with err instead of forcing the offset to alignment).
module dmem_responder #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    writedatasel,
  input  logic [2:0]    readdatasel,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic          wr;
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [DW-1:0] wdata;
    logic [1:0]    wsel;
    logic [2:0]    rsel;
  } req_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  req_t          r_req;
  logic          w_accept;
  logic          w_access;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [DW-1:0] r_mem [DEPTH];

  // Address bits above the array size are ignored so accesses wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^addr[AW-1:IW+2];

  // Next-state logic: RESP is the done cycle and accepts a new request like IDLE.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_next = S_IDLE;
        if (req) begin
          w_accept   = 1'b1;
          w_next     = S_WAIT;
          w_cnt_next = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latency counter and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_next == S_WAIT);
      r_done  <= (w_next == S_RESP);
    end
  end

  // Capture the request when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req <= '{wr: wr, idx: addr[IW+1:2], off: addr[1:0], wdata: wdata,
                 wsel: writedatasel, rsel: readdatasel};
    end
  end

  // Access size decode, shared by loads and stores.
  logic w_sz_byte;
  logic w_sz_half;
  logic w_sz_word;
  logic w_st_rsvd;
  logic w_ld_uns;
  logic w_misalign;
  always_comb begin
    w_sz_byte = 1'b0;
    w_sz_half = 1'b0;
    w_sz_word = 1'b0;
    w_st_rsvd = 1'b0;
    w_ld_uns  = (r_req.rsel == 3'b100) || (r_req.rsel == 3'b101);
    if (r_req.wr) begin
      case (r_req.wsel)
        2'b00:   w_sz_byte = 1'b1;
        2'b01:   w_sz_half = 1'b1;
        2'b10:   w_sz_word = 1'b1;
        default: w_st_rsvd = 1'b1;
      endcase
    end else begin
      case (r_req.rsel)
        3'b000, 3'b100: w_sz_byte = 1'b1;
        3'b001, 3'b101: w_sz_half = 1'b1;
        default:        w_sz_word = 1'b1;
      endcase
    end
    w_misalign = (w_sz_half && r_req.off[0]) || (w_sz_word && (r_req.off != 2'b00));
  end

  // Effective offset and error flag for the configured misalignment policy.
  logic [1:0] w_off;
  logic       w_err;
  logic       w_block;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_off   = r_req.off;
  assign w_err   = w_misalign;
  assign w_block = w_misalign;
`else
  assign w_off   = w_sz_word ? 2'b00 : (w_sz_half ? {r_req.off[1], 1'b0} : r_req.off);
  assign w_err   = 1'b0;
  assign w_block = 1'b0;
`endif

  // Store lane enables and replicated lane data.
  logic [3:0]    w_be;
  logic [DW-1:0] w_wlane;
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = r_req.wdata;
    if (w_sz_byte) begin
      w_be    = 4'(4'b0001 << w_off);
      w_wlane = {4{r_req.wdata[7:0]}};
    end else if (w_sz_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wlane = {2{r_req.wdata[15:0]}};
    end else if (w_sz_word) begin
      w_be    = 4'b1111;
    end
    if (w_st_rsvd || w_block) begin
      w_be = 4'b0000;
    end
  end

  // Load extraction with sign or zero extension.
  logic [DW-1:0] w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load;
  always_comb begin
    w_word = r_mem[r_req.idx];
    w_byte = w_word[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    if (w_sz_byte) begin
      w_load = {{24{w_byte[7] & ~w_ld_uns}}, w_byte};
    end else if (w_sz_half) begin
      w_load = {{16{w_half[15] & ~w_ld_uns}}, w_half};
    end else begin
      w_load = w_word;
    end
    if (w_block) begin
      w_load = '0;
    end
  end

  // Per-lane array write at the access edge; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_access && r_req.wr && w_be[i]) begin
        r_mem[r_req.idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  // Load result and error flag, updated at the access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err <= w_err;
      if (!r_req.wr) begin
        r_rdata <= w_load;
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a byte-addressed reference model.
module tb_dmem_responder;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned NBYTES  = DEPTH * 4;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    writedatasel;
  logic [2:0]    readdatasel;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;

  dmem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .writedatasel(writedatasel), .readdatasel(readdatasel),
    .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  mmem [NBYTES];
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, access rules from the size/offset.
  function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] ws, input logic [2:0] rs,
                                       output logic [31:0] exp_rd, output logic exp_err);
    int size;
    int off;
    int base;
    bit sgn;
    bit aligned;
    logic [31:0] v;
    off  = int'(a % 4);
    base = int'(a % NBYTES) - off;
    sgn  = 1'b0;
    if (w) size = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : (ws == 2'd2) ? 4 : 0;
    else begin
      size = (rs == 3'd0 || rs == 3'd4) ? 1 : (rs == 3'd1 || rs == 3'd5) ? 2 : 4;
      sgn  = (rs == 3'd0 || rs == 3'd1);
    end
    aligned = (size == 0) || (off % size == 0);
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!aligned) begin
      exp_err = 1'b1;
      if (!w) m_rdata = 32'h0;
      exp_rd = m_rdata;
      return;
    end
`else
    if (!aligned) off = off - (off % size);
`endif
    if (w) begin
      for (int i = 0; i < size; i++) mmem[base + off + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mmem[base + off + i]) << (8*i));
      if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      m_rdata = v;
    end
    exp_rd = m_rdata;
  endfunction

  // Issue one access, check the done latency, then check results against the model.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] ws, input logic [2:0] rs);
    int cyc;
    logic [31:0] exp_rd;
    logic exp_err;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 50) begin @(negedge clk); cyc++; end
    req = 1'b1; wr = w; addr = a; wdata = d; writedatasel = ws; readdatasel = rs;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    check("done_latency", 32'(cyc), 32'(LATENCY + 1));
    model_access(w, a, d, ws, rs, exp_rd, exp_err);
    check("rdata", rdata, exp_rd);
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d); do_access(1'b1, a, d, 2'd2, 3'd0); endtask
  task automatic ld(input logic [31:0] a, input logic [2:0] rs); do_access(1'b0, a, 32'h0, 2'd0, rs); endtask

  initial begin
    logic [31:0] exp_rd;
    logic exp_err;
    int ndone;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    writedatasel = 2'd0; readdatasel = 3'd0; m_rdata = 32'h0;
    for (int i = 0; i < int'(NBYTES); i++) mmem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);

    // Initialise the test region so every later load has a known model value.
    for (int i = 0; i < 64; i++) sw(32'(i * 4), $urandom);

    sw(32'h10, 32'hDEADBEEF);
    ld(32'h10, 3'b010);
    check("lw_deadbeef", rdata, 32'hDEADBEEF);

    sw(32'h10, 32'h11223344);
    do_access(1'b1, 32'h13, 32'h0000_0080, 2'd0, 3'd0);
    ld(32'h10, 3'b010); check("sb_lw", rdata, 32'h80223344);
    ld(32'h13, 3'b000); check("sb_lb", rdata, 32'hFFFFFF80);
    ld(32'h13, 3'b100); check("sb_lbu", rdata, 32'h00000080);

    sw(32'h20, 32'h0);
    do_access(1'b1, 32'h22, 32'h0000_BEEF, 2'd1, 3'd0);
    ld(32'h20, 3'b010); check("sh_lw", rdata, 32'hBEEF0000);
    ld(32'h22, 3'b001); check("sh_lh", rdata, 32'hFFFFBEEF);
    ld(32'h22, 3'b101); check("sh_lhu", rdata, 32'h0000BEEF);

    sw(32'h40, 32'hCAFEF00D);
    do_access(1'b1, 32'h41, 32'h12345678, 2'd2, 3'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_sw_err", 32'(err), 32'd1);
    ld(32'h40, 3'b010); check("mis_sw_word", rdata, 32'hCAFEF00D);
`else
    check("mis_sw_err", 32'(err), 32'd0);
    ld(32'h40, 3'b010); check("mis_sw_word", rdata, 32'h12345678);
`endif

    sw(32'h1000, 32'hA5A5A5A5);
    ld(32'h0, 3'b010); check("wrap_lw", rdata, 32'hA5A5A5A5);

    // Reset in the middle of WAIT abandons the store.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h55555555; writedatasel = 2'd2;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rdata = 32'h0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_err", 32'(err), 32'd0);
    ndone = 0;
    repeat (LATENCY + 3) begin @(negedge clk); if (done) ndone++; end
    check("midrst_no_done", 32'(ndone), 32'd0);
    ld(32'h10, 3'b010); check("midrst_no_write", rdata, 32'h80223344);

    // req held high: one done every LATENCY+1 cycles.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h20; readdatasel = 3'b010;
    for (int k = 1; k <= 4 * int'(LATENCY + 1); k++) begin
      @(negedge clk);
      if (k == 4 * int'(LATENCY + 1)) req = 1'b0;
      check("b2b_done", 32'(done), 32'((k % int'(LATENCY + 1)) == 0));
      if (done) check("b2b_rdata", rdata, 32'hBEEF0000);
    end
    m_rdata = 32'hBEEF0000;
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    // A req raised while busy is ignored.
    req = 1'b1; wr = 1'b0; addr = 32'h14; readdatasel = 3'b010;
    @(negedge clk);
    wr = 1'b1; wdata = 32'h0BAD0BAD; writedatasel = 2'd2;
    ndone = 0;
    for (int k = 1; k <= int'(LATENCY); k++) begin
      check("ign_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req = 1'b0;
    check("ign_done", 32'(done), 32'd1);
    model_access(1'b0, 32'h14, 32'h0, 2'd0, 3'b010, exp_rd, exp_err);
    check("ign_rdata", rdata, exp_rd);
    repeat (LATENCY + 3) begin @(negedge clk); if (done) ndone++; end
    check("ign_no_done", 32'(ndone), 32'd0);
    ld(32'h14, 3'b010);

    // Randomised mix of loads and stores, including wrapped addresses.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      do_access(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
